// File: rtl/ws2812_frame_ctl.sv
// ws2812_frame_ctl: serializes a frame of 24-bit pixels onto a WS2812 line, then holds a reset gap and pulses done
module ws2812_frame_ctl #(
  parameter int CNT_W = 8,
  parameter int RST_W = 16,
  parameter int NUM_W = 10
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic [NUM_W-1:0] pixel_num_in,
  input  logic [CNT_W-1:0] t0h_in,
  input  logic [CNT_W-1:0] t1h_in,
  input  logic [CNT_W-1:0] tbit_in,
  input  logic [RST_W-1:0] trst_in,
  input  logic             data_valid_in,
  input  logic [23:0]      data_in,
  output logic             data_ready_out,
  output logic             bit_out,
  output logic             busy_out,
  output logic             done_out,
  output logic             underrun_out
);
  typedef enum logic [1:0] {IDLE, WAIT, SEND, GAP} state_t;
  state_t state, state_n;
  logic [NUM_W-1:0] num, rem, acc;
  logic [CNT_W-1:0] t0h, t1h, tbit, cnt, cnt_n, tbe;
  logic [RST_W-1:0] trst, gcnt, trst_e;
  logic [23:0] hold, shreg, sh_n;
  logic [4:0] bidx;
  logic hold_full, accept, start_ok, bit_last, pix_last, more, drain, gap_end, bit_n;
  assign tbe = (tbit < CNT_W'(2)) ? CNT_W'(2) : tbit;
  assign trst_e = (trst == '0) ? RST_W'(1) : trst;
  assign data_ready_out = busy_out & ~hold_full & (acc < num);
  assign accept = data_valid_in & data_ready_out;
  assign start_ok = (state == IDLE) & start_in;
  assign bit_last = (state == SEND) & (cnt == tbe - CNT_W'(1));
  assign pix_last = bit_last & (bidx == 5'd0);
  assign more = (rem - NUM_W'(1)) != '0;
  assign drain = ((state == WAIT) & hold_full) | (pix_last & more & hold_full);
  assign gap_end = (state == GAP) & (gcnt == trst_e - RST_W'(1));
  // State register; reset aborts any frame in progress
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) state <= IDLE;
    else state <= state_n;
  // Next state plus the next shift/counter values that decide the registered line level
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (start_in) state_n = (pixel_num_in == '0) ? GAP : WAIT;
      WAIT: if (hold_full) state_n = SEND;
      SEND: if (pix_last) state_n = !more ? GAP : hold_full ? SEND : WAIT;
      GAP:  if (gap_end) state_n = IDLE;
    endcase
    cnt_n = (drain | bit_last | (state != SEND)) ? '0 : cnt + CNT_W'(1);
    sh_n = drain ? hold : bit_last ? {shreg[22:0], 1'b0} : shreg;
    bit_n = (state_n == SEND) & (cnt_n < (sh_n[23] ? t1h : t0h));
  end
  // Datapath: config latch, holding register, bit/pixel/gap counters and status flags
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      {num, rem, acc} <= '0;
      {t0h, t1h, tbit, cnt} <= '0;
      {trst, gcnt} <= '0;
      {hold, shreg} <= '0;
      bidx <= '0;
      {hold_full, bit_out, busy_out, done_out, underrun_out} <= '0;
    end else begin
      if (start_ok) begin
        num <= pixel_num_in;
        t0h <= t0h_in;
        t1h <= t1h_in;
        tbit <= tbit_in;
        trst <= trst_in;
      end
      rem <= start_ok ? pixel_num_in : pix_last ? rem - NUM_W'(1) : rem;
      acc <= start_ok ? '0 : acc + NUM_W'(accept);
      hold <= accept ? data_in : hold;
      hold_full <= accept | (hold_full & ~drain);
      shreg <= sh_n;
      cnt <= cnt_n;
      bidx <= drain ? 5'd23 : bit_last ? bidx - 5'd1 : bidx;
      gcnt <= (state == GAP) ? gcnt + RST_W'(1) : '0;
      underrun_out <= start_ok ? 1'b0 : (pix_last & more & ~hold_full) | underrun_out;
      busy_out <= start_ok ? (pixel_num_in != '0) : gap_end ? 1'b0 : busy_out;
      done_out <= gap_end;
      bit_out <= bit_n;
    end
endmodule
